// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Holds the sequencer state encoding and LZC width rule.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LZA,
    LZB,
    ITER,
    DONE
  } div_state_t;

  function automatic int lzc_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/lzc_iterative_divider_lzc.sv
// Combinational zero-MSB (leading-zero) counter.
// Returns N when the input word is all zeros.
module zeroMSBCounter #(
  parameter int N  = 32,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  value,
  output logic [CW-1:0] zeros
);

  logic found;

  // scan from the MSB; the first set bit fixes the count
  always_comb begin
    zeros = CW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        zeros = CW'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzc_iterative_divider.sv
// Unsigned restoring divider sequenced by a shared LZC.
// Iterates only over the significant quotient bits.
module lzc_iterative_divider
  import div_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = lzc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  div_state_t state, state_n;

  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  d;
  logic [N-1:0]  rem;
  logic [N-1:0]  q;
  logic [CW-1:0] za;
  logic [CW-1:0] cnt;

  logic [N-1:0]  lzc_in;
  logic [CW-1:0] lzc_out;
  logic [CW-1:0] shift;
  logic          early;
  logic          ge;
  logic [N-1:0]  rem_n;
  logic [N-1:0]  q_n;
  logic [CW-1:0] cnt_n;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // zb is consumed straight from the LZC in LZB
  assign early = (za > lzc_out);
  assign shift = lzc_out - za;

  assign ge    = (rem >= d);
  assign rem_n = ge ? (rem - d) : rem;
  assign q_n   = {q[N-2:0], ge};
  assign cnt_n = cnt - CW'(1);

  // one counter shared between a and b by state
  always_comb begin
    lzc_in = '0;
    unique case (1'b1)
      (state == LZA): lzc_in = a_r;
      (state == LZB): lzc_in = b_r;
      default: ;
    endcase
  end

  zeroMSBCounter #(
    .N (N),
    .CW(CW)
  ) u_lzc (
    .value(lzc_in),
    .zeros(lzc_out)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (in_valid)
          state_n = (divisor == '0) ? DONE : LZA;
      end
      LZA: state_n = LZB;
      LZB: state_n = early ? DONE : ITER;
      ITER: begin
        if (cnt_n == '0) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // operand capture, iteration datapath, results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      d           <= '0;
      rem         <= '0;
      q           <= '0;
      za          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r         <= dividend;
            b_r         <= divisor;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        LZA: za <= lzc_out;
        LZB: begin
          if (early) begin
            quotient  <= '0;
            remainder <= a_r;
          end else begin
            d   <= b_r << shift;
            rem <= a_r;
            q   <= '0;
            cnt <= shift + CW'(1);
          end
        end
        ITER: begin
          rem <= rem_n;
          q   <= q_n;
          d   <= d >> 1;
          cnt <= cnt_n;
          if (cnt_n == '0) begin
            quotient  <= q_n;
            remainder <= rem_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
